// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the pipeline bundle type.
// Counter and colour widths are common to all overlay stages.
package vga_pkg;
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
  localparam int CNT_W = 11;
  localparam int POS_W = 12;
  localparam int RGB_W = 12;
  localparam int CMP_W = 13;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;
  } vga_bus_t;

  localparam int BUS_W = $bits(vga_bus_t);
endpackage

// File: rtl/delay.sv
// Fixed-latency shift register, WIDTH bits wide and CLK_DEL stages deep.
// All stages clear asynchronously on rst_n.
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] pipe_q [CLK_DEL];
  logic [WIDTH-1:0] pipe_d [CLK_DEL];

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < CLK_DEL; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CLK_DEL; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[CLK_DEL-1];
endmodule

// File: rtl/draw_sprite.sv
// Sprite overlay stage: ROM addressing, 3-stage aligned timing, colour mux.
// Define SPRITE_KEY_EN to make KEY_COLOR sprite pixels transparent.
module draw_sprite
  import vga_pkg::*;
#(
  parameter int         SPRITE_W  = 48,
  parameter int         SPRITE_H  = 64,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
`ifdef SPRITE_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic             vblnk_prev_q, vblnk_prev_d;
  logic [POS_W-1:0] x_l_q, x_l_d;
  logic [POS_W-1:0] y_l_q, y_l_d;
  logic [11:0]      rom_addr_q, rom_addr_d;
  vga_bus_t         out_q, out_d;

  logic [CMP_W-1:0] h13, v13, x13, y13;
  logic [5:0]       rel_x, rel_y;
  logic             hit, hit_s2, keyed;
  vga_bus_t         bus_in, bus_s2;

  // Position only moves at the start of vertical blanking.
  always_comb begin
    vblnk_prev_d = vblnk_in;
    x_l_d        = x_l_q;
    y_l_d        = y_l_q;
    if (vblnk_in && !vblnk_prev_q) begin
      x_l_d = xpos;
      y_l_d = ypos;
    end
  end

  always_comb begin
    h13   = {2'b00, hcount_in};
    v13   = {2'b00, vcount_in};
    x13   = {1'b0, x_l_q};
    y13   = {1'b0, y_l_q};
    hit   = (h13 >= x13) && (h13 < x13 + CMP_W'(SPRITE_W)) &&
            (v13 >= y13) && (v13 < y13 + CMP_W'(SPRITE_H));
    rel_x = 6'(h13 - x13);
    rel_y = 6'(v13 - y13);
    rom_addr_d = hit ? {rel_y, rel_x} : 12'h000;
  end

  always_comb begin
    bus_in.hcount = hcount_in;
    bus_in.vcount = vcount_in;
    bus_in.hsync  = hsync_in;
    bus_in.vsync  = vsync_in;
    bus_in.hblnk  = hblnk_in;
    bus_in.vblnk  = vblnk_in;
    bus_in.rgb    = rgb_in;
  end

  // S1 and S2 of the bundle; rom_rgb lands alongside S2.
  delay #(
    .WIDTH  (BUS_W + 1),
    .CLK_DEL(2)
  ) u_bundle (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({hit, bus_in}),
    .dout ({hit_s2, bus_s2})
  );

  always_comb begin
    keyed = KEY_EN && (rom_rgb == KEY_COLOR);
    out_d = bus_s2;
    if (bus_s2.hblnk || bus_s2.vblnk) begin
      out_d.rgb = '0;
    end else if (hit_s2 && !keyed) begin
      out_d.rgb = rom_rgb;
    end else begin
      out_d.rgb = bus_s2.rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev_q <= 1'b0;
      x_l_q        <= '0;
      y_l_q        <= '0;
      rom_addr_q   <= '0;
      out_q        <= '0;
    end else begin
      vblnk_prev_q <= vblnk_prev_d;
      x_l_q        <= x_l_d;
      y_l_q        <= y_l_d;
      rom_addr_q   <= rom_addr_d;
      out_q        <= out_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign hcount_out = out_q.hcount;
  assign vcount_out = out_q.vcount;
  assign hsync_out  = out_q.hsync;
  assign vsync_out  = out_q.vsync;
  assign hblnk_out  = out_q.hblnk;
  assign vblnk_out  = out_q.vblnk;
  assign rgb_out    = out_q.rgb;
endmodule

// File: tb/tb_draw_sprite.sv
// Scoreboard bench for draw_sprite with a registered ROM model.
// Honours SPRITE_KEY_EN the same way as the design build.
module tb_draw_sprite;
  localparam int SW = 48;
  localparam int SH = 64;
  localparam logic [11:0] KEY = 12'hF0F;
`ifdef SPRITE_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [11:0] xpos, ypos, rgb_in, rom_addr, rom_rgb, rgb_out;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic hsync_out, vsync_out, hblnk_out, vblnk_out;

  always #5 clk = ~clk;

  logic [11:0] rom_mem [4096];
  always @(posedge clk) rom_rgb <= rom_mem[rom_addr];

  draw_sprite dut (
    .clk(clk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  typedef struct {
    logic [37:0] bus;
    int h;
    int v;
    int cyc;
  } exp_t;
  typedef struct {
    logic [11:0] addr;
    int cyc;
  } aexp_t;

  exp_t  exp_q[$];
  aexp_t adr_q[$];
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int mx_l, my_l;
  bit mprev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: one screen pixel in, one expected bus word out.
  task automatic pix(input int h, input int v, input logic [11:0] bg);
    bit hb, vb, hs, vs, hit;
    logic [11:0] addr, romv, col;
    exp_t e;
    aexp_t a;
    hb = h >= 800;
    vb = v >= 600;
    hs = h >= 840 && h < 968;
    vs = v >= 601 && v < 605;
    @(negedge clk);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in = hs;
    vsync_in = vs;
    hblnk_in = hb;
    vblnk_in = vb;
    rgb_in = bg;
    hit = h >= mx_l && h < mx_l + SW && v >= my_l && v < my_l + SH;
    addr = hit ? 12'(((v - my_l) % 64) * 64 + ((h - mx_l) % 64)) : 12'h0;
    romv = rom_mem[addr];
    if (hb || vb) col = 12'h0;
    else if (hit && !(KEY_EN && romv == KEY)) col = romv;
    else col = bg;
    e.bus = {11'(h), 11'(v), hs, vs, hb, vb, col};
    e.h = h;
    e.v = v;
    e.cyc = cyc;
    a.addr = addr;
    a.cyc = cyc;
    exp_q.push_back(e);
    adr_q.push_back(a);
    if (vb && !mprev) begin
      mx_l = int'(xpos);
      my_l = int'(ypos);
    end
    mprev = vb;
  endtask

  task automatic scan(input int h0, input int h1, input int v0,
                      input int v1, input logic [11:0] bg);
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++) pix(h, v, bg);
  endtask

  task automatic vpulse();
    for (int i = 0; i < 3; i++) pix(0, 600 + i, 12'h000);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) pix(900, 10, 12'h321);
  endtask

  task automatic rom_fill(input bit rnd, input logic [11:0] val);
    for (int i = 0; i < 4096; i++)
      rom_mem[i] = rnd ? 12'($urandom) : val;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rgb_out"}, 64'(rgb_out), 64'h0);
    chk({tag, " rom_addr"}, 64'(rom_addr), 64'h0);
    chk({tag, " counters"}, 64'({hcount_out, vcount_out}), 64'h0);
    chk({tag, " timing"},
        64'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 64'h0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (adr_q.size() > 0 && adr_q[0].cyc + 1 <= cyc) begin
        aexp_t a;
        a = adr_q.pop_front();
        chk("rom_addr", 64'(rom_addr), 64'(a.addr));
      end
      if (exp_q.size() > 0 && exp_q[0].cyc + 3 <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("pixel h=%0d v=%0d", e.h, e.v),
            64'({hcount_out, vcount_out, hsync_out, vsync_out,
                 hblnk_out, vblnk_out, rgb_out}), 64'(e.bus));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout required end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    xpos = 0; ypos = 0; hcount_in = 0; vcount_in = 0;
    hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
    rgb_in = 0; rom_rgb = 0;
    mx_l = 0; my_l = 0; mprev = 0;
    rom_fill(0, 12'h0F0);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Before any latch the sprite sits at (0,0).
    xpos = 12'd100; ypos = 12'd200;
    scan(0, 3, 0, 2, 12'h555);
    scan(46, 49, 62, 64, 12'h555);

    vpulse();
    scan(97, 150, 198, 266, 12'hABC);

    // Position change mid-frame waits for the next blanking edge.
    scan(98, 149, 199, 201, 12'hABC);
    xpos = 12'd300;
    scan(98, 149, 202, 203, 12'hABC);
    scan(297, 350, 202, 202, 12'hABC);
    vpulse();
    scan(297, 350, 199, 201, 12'hABC);
    scan(98, 149, 200, 200, 12'hABC);
    drain();

    rom_fill(1, 12'h0);
    xpos = 12'd780; ypos = 12'd10;
    vpulse();
    scan(770, 810, 8, 14, 12'h2B7);

    xpos = 12'd4000; ypos = 12'd4000;
    vpulse();
    scan(0, 40, 0, 3, 12'h6D1);
    scan(2000, 2047, 0, 1, 12'h6D1);

    // Asynchronous reset in the middle of a line.
    xpos = 12'd100; ypos = 12'd200;
    vpulse();
    scan(90, 100, 205, 205, 12'h777);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    adr_q.delete();
    mx_l = 0; my_l = 0; mprev = 0;
    #1;
    chk_zero("midreset");
    repeat (3) @(negedge clk);
    chk_zero("held");
    rst_n = 1'b1;
    scan(0, 60, 0, 1, 12'h777);
    vpulse();
    scan(95, 155, 200, 201, 12'h777);
    drain();

    rom_fill(0, KEY);
    scan(100, 105, 200, 201, 12'h123);
    drain();

    rom_fill(1, 12'h0);
    for (int k = 0; k < 10; k++) begin
      xpos = 12'($urandom_range(0, 900));
      ypos = 12'($urandom_range(0, 700));
      vpulse();
      for (int i = 0; i < 300; i++)
        pix($urandom_range(0, 1100), $urandom_range(0, 700),
            12'($urandom));
    end
    drain();

    repeat (6) @(negedge clk);
    chk("queue drained", 64'(exp_q.size() + adr_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
